// File: rtl/ws2812b_pixel_receiver.sv
// WS2812B single-wire decoder: classifies high-pulse widths into bits, packs 24-bit GRB
// pixels MSB first, and counts pixels within a frame bounded by the idle marker.
module ws2812b_pixel_receiver #(
  parameter int IDX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             idle,
  input  logic [CNT_W-1:0] bit_threshold_ticks,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic [IDX_W-1:0] frame_pixels,
  output logic             partial_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [4:0]       LAST_BIT = 5'd23;

  logic             din_q;
  logic             idle_q;
  logic [CNT_W-1:0] high_cnt;
  logic [4:0]       bit_cnt;
  logic [22:0]      shift;
  logic [IDX_W-1:0] next_idx;

  logic             rise;
  logic             fall_ev;
  logic             idle_rise;
  logic             bit_val;
  logic             pixel_end;
  logic [IDX_W-1:0] next_idx_inc;

  // Edge events; idle masks falls so a line going idle never decodes a stray bit.
  always_comb begin
    rise         = din & ~din_q;
    fall_ev      = ~din & din_q & ~idle;
    idle_rise    = idle & ~idle_q;
    bit_val      = (high_cnt > bit_threshold_ticks);
    pixel_end    = fall_ev && (bit_cnt == LAST_BIT);
    next_idx_inc = (next_idx == IDX_MAX) ? IDX_MAX : next_idx + IDX_W'(1);
  end

  // Line sampling and high-pulse width measurement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_q    <= 1'b0;
      idle_q   <= 1'b0;
      high_cnt <= '0;
    end else begin
      din_q  <= din;
      idle_q <= idle;
      if (idle) begin
        high_cnt <= '0;
      end else if (rise) begin
        high_cnt <= CNT_W'(1);
      end else if (din && din_q && (high_cnt != CNT_MAX)) begin
        high_cnt <= high_cnt + CNT_W'(1);
      end
    end
  end

  // Bit assembly and pixel emission.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      shift       <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
    end else begin
      pixel_valid <= 1'b0;
      if (idle) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else if (pixel_end) begin
        pixel_data  <= {shift, bit_val};
        pixel_valid <= 1'b1;
        pixel_index <= next_idx;
        bit_cnt     <= '0;
      end else if (fall_ev) begin
        shift   <= {shift[21:0], bit_val};
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  // Frame bookkeeping; partial_err stays set until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_idx     <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      partial_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (idle_rise) begin
        if (next_idx != IDX_ZERO) begin
          frame_done   <= 1'b1;
          frame_pixels <= next_idx;
        end
        if (bit_cnt != 5'd0) begin
          partial_err <= 1'b1;
        end
        next_idx <= '0;
      end else if (pixel_end) begin
        next_idx <= next_idx_inc;
      end
    end
  end

endmodule

// File: tb/tb_ws2812b_pixel_receiver.sv
// Directed bench for ws2812b_pixel_receiver; a narrow-index copy shares the stimulus
// so index saturation can be observed alongside the default build.
module tb_ws2812b_pixel_receiver;

  logic        clk;
  logic        reset;
  logic        din;
  logic        idle;
  logic [15:0] thr;

  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  frame_pixels;
  logic        partial_err;

  logic [23:0] pixel_data2;
  logic        pixel_valid2;
  logic [1:0]  pixel_index2;
  logic        frame_done2;
  logic [1:0]  frame_pixels2;
  logic        partial_err2;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] pv_data[$];
  logic [31:0] pv_idx[$];
  logic [31:0] pv_idx2[$];
  int          fd_cnt = 0;
  int          fd2_cnt = 0;
  int          back2back = 0;
  logic        pv_prev = 1'b0;

  ws2812b_pixel_receiver #(.IDX_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .din(din), .idle(idle), .bit_threshold_ticks(thr),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
    .frame_done(frame_done), .frame_pixels(frame_pixels), .partial_err(partial_err)
  );

  ws2812b_pixel_receiver #(.IDX_W(2), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .din(din), .idle(idle), .bit_threshold_ticks(thr),
    .pixel_data(pixel_data2), .pixel_valid(pixel_valid2), .pixel_index(pixel_index2),
    .frame_done(frame_done2), .frame_pixels(frame_pixels2), .partial_err(partial_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record pulse outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (pixel_valid) begin
      pv_data.push_back({8'h00, pixel_data});
      pv_idx.push_back({24'h0, pixel_index});
    end
    if (pixel_valid2) pv_idx2.push_back({30'h0, pixel_index2});
    if (frame_done) fd_cnt++;
    if (frame_done2) fd2_cnt++;
    if (pixel_valid && pv_prev) back2back++;
    pv_prev = pixel_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic b, input int hi1, input int lo1, input int hi0, input int lo0);
    din = 1'b1;
    tick(b ? hi1 : hi0);
    din = 1'b0;
    tick(b ? lo1 : lo0);
  endtask

  // Sends the top nbits of px, MSB first.
  task automatic applyStimulus(input logic [23:0] px, input int nbits,
                               input int hi1, input int lo1, input int hi0, input int lo0);
    for (int i = 23; i > 23 - nbits; i--) send_bit(px[i], hi1, lo1, hi0, lo0);
  endtask

  task automatic send_pixel(input logic [23:0] px);
    applyStimulus(px, 24, 50, 30, 20, 60);
  endtask

  task automatic idle_pulse();
    idle = 1'b1;
    tick(4);
    idle = 1'b0;
    tick(2);
  endtask

  task automatic clear_logs();
    pv_data.delete();
    pv_idx.delete();
    pv_idx2.delete();
    fd_cnt    = 0;
    fd2_cnt   = 0;
    back2back = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    din   = 1'b0;
    idle  = 1'b0;
    thr   = 16'd40;
    tick(3);
    checkOutput("rst_data",   {8'h0, pixel_data}, 32'h0);
    checkOutput("rst_valid",  {31'h0, pixel_valid}, 32'h0);
    checkOutput("rst_index",  {24'h0, pixel_index}, 32'h0);
    checkOutput("rst_fdone",  {31'h0, frame_done}, 32'h0);
    checkOutput("rst_fpix",   {24'h0, frame_pixels}, 32'h0);
    checkOutput("rst_perr",   {31'h0, partial_err}, 32'h0);
    reset = 1'b0;
    tick(3);

    $display("[TB] single pixel 0xA5C30F");
    clear_logs();
    send_pixel(24'hA5C30F);
    checkOutput("t1_count", pv_data.size(), 32'd1);
    checkOutput("t1_data",  pv_data[0], 32'h00A5C30F);
    checkOutput("t1_index", pv_idx[0], 32'd0);

    $display("[TB] three-pixel frame");
    idle_pulse();
    checkOutput("t2_prev_fdone", fd_cnt, 32'd1);
    checkOutput("t2_prev_fpix",  {24'h0, frame_pixels}, 32'd1);
    clear_logs();
    send_pixel(24'h112233);
    send_pixel(24'h445566);
    send_pixel(24'h778899);
    idle_pulse();
    checkOutput("t2_count",  pv_data.size(), 32'd3);
    checkOutput("t2_data0",  pv_data[0], 32'h00112233);
    checkOutput("t2_data1",  pv_data[1], 32'h00445566);
    checkOutput("t2_data2",  pv_data[2], 32'h00778899);
    checkOutput("t2_idx0",   pv_idx[0], 32'd0);
    checkOutput("t2_idx1",   pv_idx[1], 32'd1);
    checkOutput("t2_idx2",   pv_idx[2], 32'd2);
    checkOutput("t2_fdone",  fd_cnt, 32'd1);
    checkOutput("t2_fpix",   {24'h0, frame_pixels}, 32'd3);
    checkOutput("t2_b2b",    back2back, 32'd0);

    $display("[TB] threshold boundary 41/40");
    clear_logs();
    applyStimulus(24'h800001, 24, 41, 40, 40, 40);
    checkOutput("t3_count", pv_data.size(), 32'd1);
    checkOutput("t3_data",  pv_data[0], 32'h00800001);
    checkOutput("t3_index", pv_idx[0], 32'd0);

    $display("[TB] partial pixel then idle");
    idle_pulse();
    clear_logs();
    applyStimulus(24'hFFC000, 10, 50, 30, 20, 60);
    idle = 1'b1;
    tick(4);
    checkOutput("t4_count", pv_data.size(), 32'd0);
    checkOutput("t4_fdone", fd_cnt, 32'd0);
    checkOutput("t4_perr",  {31'h0, partial_err}, 32'd1);
    idle = 1'b0;
    tick(2);
    send_pixel(24'h5A3CC3);
    checkOutput("t4_next_count", pv_data.size(), 32'd1);
    checkOutput("t4_next_data",  pv_data[0], 32'h005A3CC3);
    checkOutput("t4_next_index", pv_idx[0], 32'd0);

    $display("[TB] asynchronous reset mid-pixel");
    idle_pulse();
    checkOutput("t5_pre_fpix", {24'h0, frame_pixels}, 32'd1);
    clear_logs();
    applyStimulus(24'hFFF000, 12, 50, 30, 20, 60);
    din = 1'b1;
    tick(20);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t5_data",  {8'h0, pixel_data}, 32'h0);
    checkOutput("t5_index", {24'h0, pixel_index}, 32'h0);
    checkOutput("t5_fpix",  {24'h0, frame_pixels}, 32'h0);
    checkOutput("t5_perr",  {31'h0, partial_err}, 32'h0);
    checkOutput("t5_valid", {31'h0, pixel_valid}, 32'h0);
    din = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(3);
    send_pixel(24'h0F0F0F);
    checkOutput("t5_count", pv_data.size(), 32'd1);
    checkOutput("t5_after_data",  pv_data[0], 32'h000F0F0F);
    checkOutput("t5_after_index", pv_idx[0], 32'd0);
    checkOutput("t5_no_fdone", fd_cnt, 32'd0);

    $display("[TB] index saturation with narrow index");
    idle_pulse();
    clear_logs();
    send_pixel(24'h010203);
    send_pixel(24'h040506);
    send_pixel(24'h070809);
    send_pixel(24'h0A0B0C);
    send_pixel(24'h0D0E0F);
    idle_pulse();
    checkOutput("t6_count2", pv_idx2.size(), 32'd5);
    checkOutput("t6_idx2_2", pv_idx2[2], 32'd2);
    checkOutput("t6_idx2_3", pv_idx2[3], 32'd3);
    checkOutput("t6_idx2_4", pv_idx2[4], 32'd3);
    checkOutput("t6_fpix2",  {30'h0, frame_pixels2}, 32'd3);
    checkOutput("t6_fdone2", fd2_cnt, 32'd1);
    checkOutput("t6_idx_4",  pv_idx[4], 32'd4);
    checkOutput("t6_data_4", pv_data[4], 32'h000D0E0F);
    checkOutput("t6_fpix",   {24'h0, frame_pixels}, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
